transmissor_medida: RTL



---
 rtl/transmissor_medida.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/transmissor_medida.sv
// UART sender for a three-digit BCD distance: "HTU#" as ASCII, 8N1 frames.
// Define TRANSMISSOR_PARIDADE_EN to switch to 8E1 (even parity before stop).
module transmissor_medida #(
  parameter int CLKS_PER_BIT = 434,
  parameter int N            = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [3:0] digito2,
  input  logic [3:0] digito1,
  input  logic [3:0] digito0,
  output logic       saida_serial,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

`ifdef TRANSMISSOR_PARIDADE_EN
  localparam int FRAME_W = 11;
`else
  localparam int FRAME_W = 10;
`endif

  localparam logic [N-1:0] TICK_LAST = N'(CLKS_PER_BIT - 1);
  localparam logic [N-1:0] TICK_ONE  = N'(1);
  localparam logic [3:0]   BIT_LAST  = 4'(FRAME_W - 1);

  typedef enum logic [1:0] {
    INICIAL     = 2'd0,
    PREPARACAO  = 2'd1,
    TRANSMISSAO = 2'd2,
    FINAL       = 2'd3
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [N-1:0]       tick_q, tick_d;
  logic [3:0]         bit_q, bit_d;
  logic [1:0]         idx_q, idx_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [3:0]         dig2_q, dig2_d;
  logic [3:0]         dig1_q, dig1_d;
  logic [3:0]         dig0_q, dig0_d;
  logic               serial_q, serial_d;
  logic               ocupado_q, ocupado_d;
  logic               pronto_q, pronto_d;
  logic [FRAME_W-1:0] frame_s;

  function automatic logic [7:0] char_byte(input logic [1:0] idx,
                                           input logic [3:0] d2,
                                           input logic [3:0] d1,
                                           input logic [3:0] d0);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h30 + {4'h0, d2};
      2'd1:    b = 8'h30 + {4'h0, d1};
      2'd2:    b = 8'h30 + {4'h0, d0};
      default: b = 8'h23;
    endcase
    return b;
  endfunction

`ifdef TRANSMISSOR_PARIDADE_EN
  function automatic logic parity_even(input logic [7:0] d);
    return ^d;
  endfunction

  function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] d);
    return {1'b1, parity_even(d), d, 1'b0};
  endfunction
`else
  function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction
`endif

  assign frame_s = build_frame(char_byte(idx_q, dig2_q, dig1_q, dig0_q));

  // Next-state and next-output logic; outputs are registered on the transition edge
  always_comb begin
    estado_d  = estado_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    dig2_d    = dig2_q;
    dig1_d    = dig1_q;
    dig0_d    = dig0_q;
    serial_d  = serial_q;
    ocupado_d = ocupado_q;
    pronto_d  = 1'b0;
    case (estado_q)
      INICIAL: begin
        serial_d = 1'b1;
        if (partida) begin
          dig2_d    = digito2;
          dig1_d    = digito1;
          dig0_d    = digito0;
          idx_d     = 2'd0;
          tick_d    = '0;
          bit_d     = 4'd0;
          ocupado_d = 1'b1;
          estado_d  = PREPARACAO;
        end else begin
          ocupado_d = 1'b0;
          estado_d  = INICIAL;
        end
      end
      PREPARACAO: begin
        shift_d   = frame_s;
        tick_d    = '0;
        bit_d     = 4'd0;
        serial_d  = frame_s[0];
        ocupado_d = 1'b1;
        estado_d  = TRANSMISSAO;
      end
      TRANSMISSAO: begin
        ocupado_d = 1'b1;
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d    = 4'd0;
            serial_d = 1'b1;
            if (idx_q != 2'd3) begin
              idx_d    = idx_q + 2'd1;
              estado_d = PREPARACAO;
            end else begin
              ocupado_d = 1'b0;
              pronto_d  = 1'b1;
              estado_d  = FINAL;
            end
          end else begin
            // Shifted copy keeps the next bit at [0]; the pin gets it this edge
            bit_d    = bit_q + 4'd1;
            shift_d  = {1'b1, shift_q[FRAME_W-1:1]};
            serial_d = shift_q[1];
          end
        end else begin
          tick_d = tick_q + TICK_ONE;
        end
      end
      FINAL: begin
        serial_d  = 1'b1;
        ocupado_d = 1'b0;
        estado_d  = INICIAL;
      end
      default: begin
        serial_d  = 1'b1;
        ocupado_d = 1'b0;
        estado_d  = INICIAL;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q  <= INICIAL;
      tick_q    <= '0;
      bit_q     <= 4'd0;
      idx_q     <= 2'd0;
      shift_q   <= {FRAME_W{1'b1}};
      dig2_q    <= 4'd0;
      dig1_q    <= 4'd0;
      dig0_q    <= 4'd0;
      serial_q  <= 1'b1;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      dig2_q    <= dig2_d;
      dig1_q    <= dig1_d;
      dig0_q    <= dig0_d;
      serial_q  <= serial_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
    end
  end

  assign saida_serial = serial_q;
  assign ocupado      = ocupado_q;
  assign pronto       = pronto_q;
  assign db_estado    = {2'b00, estado_q};

endmodule
